// File: rtl/load_pkg.sv
// Shared types, constants and helpers for the load execution unit.
package load_pkg;

  // Load control encoding; codes 0-6 follow the RISC-V load funct3 field.
  typedef enum logic [2:0] {
    LB     = 3'd0,
    LH     = 3'd1,
    LW     = 3'd2,
    LD     = 3'd3,
    LBU    = 3'd4,
    LHU    = 3'd5,
    LWU    = 3'd6,
    LD_NOP = 3'd7
  } load_ctrl_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP,
    S_EXC
  } load_state_t;

  localparam logic EXC_MISALIGNED = 1'b0;
  localparam logic EXC_ILLEGAL    = 1'b1;

  // LD and LWU only exist on a 64-bit datapath.
  function automatic logic ctrl_legal(input load_ctrl_t ctrl, input int xlen);
    logic ok;
    case (ctrl)
      LB, LH, LW, LBU, LHU, LD_NOP: ok = 1'b1;
      LD, LWU:                      ok = (xlen == 64);
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Natural alignment check on the low effective-address bits.
  function automatic logic ctrl_aligned(input load_ctrl_t ctrl, input logic [2:0] low);
    logic ok;
    case (ctrl)
      LH, LHU: ok = (low[0] == 1'b0);
      LW, LWU: ok = (low[1:0] == 2'b00);
      LD:      ok = (low == 3'b000);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Request, data-memory and writeback/exception signals of the load unit.
interface load_unit_if
  import load_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = XLEN
) ();

  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   rs1_val;
  logic [11:0]       imm;
  load_ctrl_t        load_control;
  logic [4:0]        rd_in;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rdata;

  logic              wb_valid;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              exc_valid;
  logic              exc_cause;
  logic [ADDR_W-1:0] exc_addr;

  // Environment side: decoder, data memory and writeback consumer.
  modport master (
    output req_valid, rs1_val, imm, load_control, rd_in,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, mem_req_valid, mem_addr,
    input  wb_valid, wb_we, wb_rd, wb_data,
    input  exc_valid, exc_cause, exc_addr
  );

  // Load unit side.
  modport slave (
    input  req_valid, rs1_val, imm, load_control, rd_in,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, mem_req_valid, mem_addr,
    output wb_valid, wb_we, wb_rd, wb_data,
    output exc_valid, exc_cause, exc_addr
  );

endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/half/word/double out of an aligned memory word
// and sign- or zero-extends it to the datapath width.
module load_align
  import load_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] offset,
  input  load_ctrl_t       ctrl,
  output logic [XLEN-1:0]  result
);

  logic [XLEN-1:0] shifted;

  // Little-endian lane select followed by extension chosen by load type.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    result  = '0;
    case (ctrl)
      LB:      result = XLEN'($signed(shifted[7:0]));
      LH:      result = XLEN'($signed(shifted[15:0]));
      LW:      result = XLEN'($signed(shifted[31:0]));
      LBU:     result = XLEN'(shifted[7:0]);
      LHU:     result = XLEN'(shifted[15:0]);
      LWU:     result = XLEN'(shifted[31:0]);
      LD:      result = (XLEN == 64) ? shifted : '0;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load execution unit: effective address, memory handshake, lane extract
// and a single-cycle writeback or exception pulse. One load in flight.
module load_unit
  import load_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = XLEN
) (
  input  logic        clk,
  input  logic        rst,
  load_unit_if.slave  bus
);

  localparam int OFF_W = $clog2(XLEN / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(XLEN / 8 - 1);

  load_state_t       state, state_n;
  logic [XLEN-1:0]   ea_full;
  logic [ADDR_W-1:0] ea;
  logic              req_legal;
  logic              req_aligned;
  logic              accept;

  logic [ADDR_W-1:0] ea_q;
  load_ctrl_t        ctrl_q;
  logic [4:0]        rd_q;
  logic              cause_q;
  logic [XLEN-1:0]   data_q;
  logic [XLEN-1:0]   aligned_data;

  assign ea_full     = bus.rs1_val + XLEN'($signed(bus.imm));
  assign ea          = ea_full[ADDR_W-1:0];
  assign req_legal   = ctrl_legal(bus.load_control, XLEN);
  assign req_aligned = ctrl_aligned(bus.load_control, ea[2:0]);
  assign accept      = (state == S_IDLE) && bus.req_valid;

  load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
    .rdata  (bus.mem_rdata),
    .offset (ea_q[OFF_W-1:0]),
    .ctrl   (ctrl_q),
    .result (aligned_data)
  );

  // State register; reset abandons any in-flight load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Latch the accepted load and capture the extended response data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea_q    <= '0;
      ctrl_q  <= LB;
      rd_q    <= '0;
      cause_q <= EXC_MISALIGNED;
      data_q  <= '0;
    end else begin
      if (accept) begin
        ea_q    <= ea;
        ctrl_q  <= bus.load_control;
        rd_q    <= bus.rd_in;
        cause_q <= req_legal ? EXC_MISALIGNED : EXC_ILLEGAL;
      end
      if ((state == S_WAIT) && bus.mem_rsp_valid) data_q <= aligned_data;
    end
  end

  // Next state and Moore outputs; result fields read zero outside their pulse.
  always_comb begin
    state_n           = state;
    bus.req_ready     = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_addr      = '0;
    bus.wb_valid      = 1'b0;
    bus.wb_we         = 1'b0;
    bus.wb_rd         = '0;
    bus.wb_data       = '0;
    bus.exc_valid     = 1'b0;
    bus.exc_cause     = 1'b0;
    bus.exc_addr      = '0;
    case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (bus.load_control == LD_NOP)       state_n = S_IDLE;
          else if (!req_legal || !req_aligned)  state_n = S_EXC;
          else                                  state_n = S_REQ;
        end
      end
      S_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_addr      = ea_q & ALIGN_MASK;
        if (bus.mem_req_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) state_n = S_RESP;
      end
      S_RESP: begin
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd_q;
        bus.wb_we    = (rd_q != 5'd0);
        bus.wb_data  = data_q;
        state_n      = S_IDLE;
      end
      S_EXC: begin
        bus.exc_valid = 1'b1;
        bus.exc_cause = cause_q;
        bus.exc_addr  = ea_q;
        state_n       = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit, exercising a 32-bit and a 64-bit build.
module tb_load_unit;
  import load_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   sel64 = 1'b0;
  int   check_count = 0;
  int   pass_count = 0;

  load_unit_if #(.XLEN(32)) b32 ();
  load_unit_if #(.XLEN(64)) b64 ();

  load_unit #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  load_unit #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  always #5 clk = ~clk;

  logic        obs_req_ready, obs_mem_req_valid, obs_wb_valid, obs_wb_we;
  logic        obs_exc_valid, obs_exc_cause;
  logic [4:0]  obs_wb_rd;
  logic [63:0] obs_mem_addr, obs_wb_data, obs_exc_addr;

  assign obs_req_ready     = sel64 ? b64.req_ready     : b32.req_ready;
  assign obs_mem_req_valid = sel64 ? b64.mem_req_valid : b32.mem_req_valid;
  assign obs_wb_valid      = sel64 ? b64.wb_valid      : b32.wb_valid;
  assign obs_wb_we         = sel64 ? b64.wb_we         : b32.wb_we;
  assign obs_wb_rd         = sel64 ? b64.wb_rd         : b32.wb_rd;
  assign obs_exc_valid     = sel64 ? b64.exc_valid     : b32.exc_valid;
  assign obs_exc_cause     = sel64 ? b64.exc_cause     : b32.exc_cause;
  assign obs_mem_addr      = sel64 ? b64.mem_addr      : {32'h0, b32.mem_addr};
  assign obs_wb_data       = sel64 ? b64.wb_data       : {32'h0, b32.wb_data};
  assign obs_exc_addr      = sel64 ? b64.exc_addr      : {32'h0, b32.exc_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clearInputs();
    b32.req_valid = 0; b32.rs1_val = '0; b32.imm = '0; b32.load_control = LB; b32.rd_in = '0;
    b32.mem_req_ready = 0; b32.mem_rsp_valid = 0; b32.mem_rdata = '0;
    b64.req_valid = 0; b64.rs1_val = '0; b64.imm = '0; b64.load_control = LB; b64.rd_in = '0;
    b64.mem_req_ready = 0; b64.mem_rsp_valid = 0; b64.mem_rdata = '0;
  endtask

  task automatic applyStimulus(input logic [63:0] rs1, input logic [11:0] imm,
                               input load_ctrl_t ctrl, input logic [4:0] rd);
    if (sel64) begin
      b64.rs1_val = rs1; b64.imm = imm; b64.load_control = ctrl; b64.rd_in = rd; b64.req_valid = 1;
    end else begin
      b32.rs1_val = rs1[31:0]; b32.imm = imm; b32.load_control = ctrl; b32.rd_in = rd; b32.req_valid = 1;
    end
  endtask

  task automatic dropReq();
    b32.req_valid = 0;
    b64.req_valid = 0;
  endtask

  task automatic setMem(input logic rdy, input logic rsp, input logic [63:0] rdata);
    if (sel64) begin
      b64.mem_req_ready = rdy; b64.mem_rsp_valid = rsp; b64.mem_rdata = rdata;
    end else begin
      b32.mem_req_ready = rdy; b32.mem_rsp_valid = rsp; b32.mem_rdata = rdata[31:0];
    end
  endtask

  // Zero-wait load: request at N+1, response at N+2, writeback at N+3.
  task automatic runLoad(input string tag, input logic [63:0] rs1, input logic [11:0] imm,
                         input load_ctrl_t ctrl, input logic [4:0] rd, input logic [63:0] rdata,
                         input logic [63:0] exp_addr, input logic [63:0] exp_data);
    applyStimulus(rs1, imm, ctrl, rd);
    checkOutput({tag, " req_ready"}, obs_req_ready, 1);
    tick();
    dropReq();
    checkOutput({tag, " mem_req_valid"}, obs_mem_req_valid, 1);
    checkOutput({tag, " mem_addr"}, obs_mem_addr, exp_addr);
    setMem(1, 0, 64'h0);
    tick();
    checkOutput({tag, " wb early"}, obs_wb_valid, 0);
    setMem(0, 1, rdata);
    tick();
    setMem(0, 0, 64'h0);
    checkOutput({tag, " wb_valid"}, obs_wb_valid, 1);
    checkOutput({tag, " wb_data"}, obs_wb_data, exp_data);
    checkOutput({tag, " wb_rd"}, 64'(obs_wb_rd), 64'(rd));
    checkOutput({tag, " wb_we"}, 64'(obs_wb_we), 64'(rd != 5'd0));
    tick();
    checkOutput({tag, " wb pulse end"}, obs_wb_valid, 0);
    checkOutput({tag, " ready again"}, obs_req_ready, 1);
  endtask

  // Faulting load: exception at N+1, ready at N+2, never a memory request.
  task automatic runFault(input string tag, input logic [63:0] rs1, input logic [11:0] imm,
                          input load_ctrl_t ctrl, input logic exp_cause, input logic [63:0] exp_addr);
    applyStimulus(rs1, imm, ctrl, 5'd3);
    tick();
    dropReq();
    checkOutput({tag, " exc_valid"}, obs_exc_valid, 1);
    checkOutput({tag, " exc_cause"}, 64'(obs_exc_cause), 64'(exp_cause));
    checkOutput({tag, " exc_addr"}, obs_exc_addr, exp_addr);
    checkOutput({tag, " no mem req"}, obs_mem_req_valid, 0);
    checkOutput({tag, " busy"}, obs_req_ready, 0);
    tick();
    checkOutput({tag, " exc pulse end"}, obs_exc_valid, 0);
    checkOutput({tag, " ready again"}, obs_req_ready, 1);
    checkOutput({tag, " still no mem req"}, obs_mem_req_valid, 0);
  endtask

  // Main directed sequence.
  initial begin
    int wb_cnt, wb_k, req_cycles, bad_addr, bad_ready;
    logic [63:0] wb_seen;
    clearInputs();
    rst = 1;
    tick();
    tick();
    checkOutput("rst req_ready", b32.req_ready, 1);
    checkOutput("rst mem_req_valid", b32.mem_req_valid, 0);
    checkOutput("rst mem_addr", 64'(b32.mem_addr), 0);
    checkOutput("rst wb_valid", b32.wb_valid, 0);
    checkOutput("rst wb_data", 64'(b32.wb_data), 0);
    checkOutput("rst wb_rd", 64'(b32.wb_rd), 0);
    checkOutput("rst exc_valid", b32.exc_valid, 0);
    checkOutput("rst exc_addr", 64'(b32.exc_addr), 0);
    checkOutput("rst64 req_ready", b64.req_ready, 1);
    rst = 0;
    tick();

    sel64 = 0;
    runLoad("lw",    64'h1000, 12'd4,   LW,  5'd5, 64'hDEADBEEF, 64'h1004, 64'hDEADBEEF);
    runLoad("lb",    64'h2000, 12'd3,   LB,  5'd7, 64'h80FF0000, 64'h2000, 64'hFFFFFF80);
    runLoad("lbu",   64'h2010, 12'hFF3, LBU, 5'd8, 64'h80FF0000, 64'h2000, 64'h00000080);
    runLoad("lh",    64'h2000, 12'd2,   LH,  5'd9, 64'h80FF0000, 64'h2000, 64'hFFFF80FF);
    runLoad("lhu x0", 64'h2000, 12'd0,  LHU, 5'd0, 64'h1234ABCD, 64'h2000, 64'h0000ABCD);
    runFault("lh misaligned", 64'h1000, 12'd1, LH,  1'b0, 64'h1001);
    runFault("lw misaligned", 64'h1000, 12'd2, LW,  1'b0, 64'h1002);
    runFault("ld on rv32",    64'h1000, 12'd0, LD,  1'b1, 64'h1000);
    runFault("lwu on rv32",   64'h1000, 12'd4, LWU, 1'b1, 64'h1004);

    applyStimulus(64'h1000, 12'd0, LD_NOP, 5'd4);
    tick();
    dropReq();
    checkOutput("nop ready", obs_req_ready, 1);
    checkOutput("nop no mem req", obs_mem_req_valid, 0);
    checkOutput("nop no exc", obs_exc_valid, 0);
    tick();
    checkOutput("nop no wb", obs_wb_valid, 0);

    // Request stalled 4 cycles, response 3 cycles after acceptance, stray response in REQ.
    wb_cnt = 0; wb_k = 0; req_cycles = 0; bad_addr = 0; bad_ready = 0; wb_seen = '0;
    applyStimulus(64'h3000, 12'd8, LW, 5'd10);
    tick();
    dropReq();
    for (int k = 1; k <= 14; k++) begin
      setMem(k == 5, (k == 2) || (k == 8), 64'h91223344);
      if (obs_mem_req_valid) begin
        req_cycles++;
        if (obs_mem_addr != 64'h3008) bad_addr++;
      end
      if (obs_wb_valid) begin
        wb_cnt++;
        wb_k = k;
        wb_seen = obs_wb_data;
      end
      if (k <= 9 && obs_req_ready) bad_ready++;
      if (k == 10) checkOutput("stall ready after pulse", obs_req_ready, 1);
      tick();
    end
    setMem(0, 0, 64'h0);
    checkOutput("stall req cycles", 64'(req_cycles), 5);
    checkOutput("stall addr stable", 64'(bad_addr), 0);
    checkOutput("stall wb count", 64'(wb_cnt), 1);
    checkOutput("stall wb cycle", 64'(wb_k), 9);
    checkOutput("stall wb data", wb_seen, 64'h91223344);
    checkOutput("stall ready low", 64'(bad_ready), 0);

    // Reset while waiting for the response.
    applyStimulus(64'h4000, 12'd0, LW, 5'd11);
    tick();
    dropReq();
    setMem(1, 0, 64'h0);
    tick();
    setMem(0, 0, 64'h0);
    rst = 1;
    #2;
    checkOutput("rst wait req_ready", obs_req_ready, 1);
    checkOutput("rst wait mem_req_valid", obs_mem_req_valid, 0);
    checkOutput("rst wait wb_valid", obs_wb_valid, 0);
    checkOutput("rst wait mem_addr", obs_mem_addr, 0);
    #1;
    rst = 0;
    setMem(0, 1, 64'hFFFFFFFF);
    tick();
    setMem(0, 0, 64'h0);
    checkOutput("stray rsp no wb", obs_wb_valid, 0);
    tick();
    checkOutput("stray rsp no wb later", obs_wb_valid, 0);
    checkOutput("stray rsp no exc", obs_exc_valid, 0);
    checkOutput("stray rsp ready", obs_req_ready, 1);
    runLoad("after rst", 64'h4000, 12'h010, LW, 5'd12, 64'hCAFEF00D, 64'h4010, 64'hCAFEF00D);

    sel64 = 1;
    runLoad("ld64",  64'h0, 12'd8,  LD,  5'd1, 64'h0123456789ABCDEF, 64'h8, 64'h0123456789ABCDEF);
    runLoad("lwu64", 64'h0, 12'd12, LWU, 5'd2, 64'h0123456789ABCDEF, 64'h8, 64'h0000000001234567);
    runLoad("lw64",  64'h0, 12'd4,  LW,  5'd3, 64'h8000000000000000, 64'h0, 64'hFFFFFFFF80000000);
    runLoad("lbu64", 64'h100, 12'hFFF, LBU, 5'd4, 64'hAB00000000000000, 64'hF8, 64'h00000000000000AB);
    runFault("ld64 misaligned", 64'h0, 12'd4, LD, 1'b0, 64'h4);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
